// File: rtl/id_ex_ctrl_if.sv
// ID/EX control bundle: decoded instruction in, registered EX bundle and
// IF/ID stall/flush controls out. The stage itself connects to the slave modport.
interface id_ex_ctrl_if #(
   parameter int PC_W   = 32,
   parameter int REG_AW = 5
);
   logic              halt;
   logic              id_valid;
   logic [14:0]       id_ctrl;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic [REG_AW-1:0] id_rd;
   logic              id_rs1_rd;
   logic              id_rs2_rd;
   logic [PC_W-1:0]   id_pc;
   logic              ex_redirect;
   logic              ex_valid;
   logic [14:0]       ex_ctrl;
   logic [REG_AW-1:0] ex_rs1;
   logic [REG_AW-1:0] ex_rs2;
   logic [REG_AW-1:0] ex_rd;
   logic [PC_W-1:0]   ex_pc;
   logic              stall_if_id;
   logic              flush_if_id;

   modport master (
      output halt, id_valid, id_ctrl, id_rs1, id_rs2, id_rd,
             id_rs1_rd, id_rs2_rd, id_pc, ex_redirect,
      input  ex_valid, ex_ctrl, ex_rs1, ex_rs2, ex_rd, ex_pc,
             stall_if_id, flush_if_id
   );

   modport slave (
      input  halt, id_valid, id_ctrl, id_rs1, id_rs2, id_rd,
             id_rs1_rd, id_rs2_rd, id_pc, ex_redirect,
      output ex_valid, ex_ctrl, ex_rs1, ex_rs2, ex_rd, ex_pc,
             stall_if_id, flush_if_id
   );
endinterface

// File: rtl/id_ex_ctrl_stage.sv
// ID->EX control pipeline register with load-use interlock and redirect flush.
// Optional ID_EX_PERF_CNT_EN adds saturating load-use / flush bubble counters.
module id_ex_ctrl_stage #(
   parameter int PC_W   = 32,
   parameter int REG_AW = 5
) (
   input  logic        clk,
   input  logic        rst,
`ifdef ID_EX_PERF_CNT_EN
   output logic [31:0] cnt_loaduse,
   output logic [31:0] cnt_flush,
`endif
   id_ex_ctrl_if.slave bus
);

   logic              r_ex_valid;
   logic [14:0]       r_ex_ctrl;
   logic [REG_AW-1:0] r_ex_rs1;
   logic [REG_AW-1:0] r_ex_rs2;
   logic [REG_AW-1:0] r_ex_rd;
   logic [PC_W-1:0]   r_ex_pc;

   logic w_ex_load;
   logic w_rs1_hit;
   logic w_rs2_hit;
   logic w_hz;

   // MemToReg (bit14) or LBU (bit3) marks a load whose data is not yet bypassable
   assign w_ex_load = r_ex_valid & (r_ex_ctrl[14] | r_ex_ctrl[3]);
   assign w_rs1_hit = bus.id_rs1_rd & (bus.id_rs1 == r_ex_rd);
   assign w_rs2_hit = bus.id_rs2_rd & (bus.id_rs2 == r_ex_rd);
   assign w_hz      = w_ex_load & (r_ex_rd != '0) & bus.id_valid & (w_rs1_hit | w_rs2_hit);

   assign bus.stall_if_id = bus.halt | (w_hz & ~bus.ex_redirect);
   assign bus.flush_if_id = bus.ex_redirect & ~bus.halt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ex_valid <= 1'b0;
         r_ex_ctrl  <= '0;
         r_ex_rs1   <= '0;
         r_ex_rs2   <= '0;
         r_ex_rd    <= '0;
         r_ex_pc    <= '0;
      end else if (bus.halt) begin
         r_ex_valid <= r_ex_valid;
      end else if (bus.ex_redirect || w_hz) begin
         r_ex_valid <= 1'b0;
         r_ex_ctrl  <= '0;
         r_ex_rs1   <= '0;
         r_ex_rs2   <= '0;
         r_ex_rd    <= '0;
         r_ex_pc    <= '0;
      end else begin
         r_ex_valid <= bus.id_valid;
         r_ex_ctrl  <= bus.id_valid ? bus.id_ctrl : 15'd0;
         r_ex_rs1   <= bus.id_rs1;
         r_ex_rs2   <= bus.id_rs2;
         r_ex_rd    <= bus.id_rd;
         r_ex_pc    <= bus.id_pc;
      end
   end

   assign bus.ex_valid = r_ex_valid;
   assign bus.ex_ctrl  = r_ex_ctrl;
   assign bus.ex_rs1   = r_ex_rs1;
   assign bus.ex_rs2   = r_ex_rs2;
   assign bus.ex_rd    = r_ex_rd;
   assign bus.ex_pc    = r_ex_pc;

`ifdef ID_EX_PERF_CNT_EN
   logic [31:0] r_cnt_loaduse;
   logic [31:0] r_cnt_flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt_loaduse <= '0;
         r_cnt_flush   <= '0;
      end else if (!bus.halt) begin
         if (bus.ex_redirect) begin
            if (r_cnt_flush != 32'hFFFF_FFFF) r_cnt_flush <= r_cnt_flush + 32'd1;
         end else if (w_hz) begin
            if (r_cnt_loaduse != 32'hFFFF_FFFF) r_cnt_loaduse <= r_cnt_loaduse + 32'd1;
         end
      end
   end

   assign cnt_loaduse = r_cnt_loaduse;
   assign cnt_flush   = r_cnt_flush;
`endif

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Directed self-checking bench for id_ex_ctrl_stage; counter checks compile in
// only when ID_EX_PERF_CNT_EN is defined.
module tb_id_ex_ctrl_stage;
   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   id_ex_ctrl_if #(.PC_W(32), .REG_AW(5)) bus ();

`ifdef ID_EX_PERF_CNT_EN
   logic [31:0] cnt_loaduse;
   logic [31:0] cnt_flush;
   id_ex_ctrl_stage #(.PC_W(32), .REG_AW(5)) dut (
      .clk(clk), .rst(rst), .cnt_loaduse(cnt_loaduse), .cnt_flush(cnt_flush), .bus(bus));
`else
   id_ex_ctrl_stage #(.PC_W(32), .REG_AW(5)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [14:0] c, input logic [4:0] rs1,
                         input logic r1, input logic [4:0] rs2, input logic r2,
                         input logic [4:0] rd, input logic [31:0] pc);
      bus.id_valid  = v;
      bus.id_ctrl   = c;
      bus.id_rs1    = rs1;
      bus.id_rs1_rd = r1;
      bus.id_rs2    = rs2;
      bus.id_rs2_rd = r2;
      bus.id_rd     = rd;
      bus.id_pc     = pc;
      #1;
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst = 1'b1;
      bus.halt = 1'b0;
      bus.ex_redirect = 1'b0;
      set_id(1'b0, 15'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
      tick();
      chk("rst_valid", {31'd0, bus.ex_valid}, 32'd0);
      chk("rst_stall", {31'd0, bus.stall_if_id}, 32'd0);
      chk("rst_flush", {31'd0, bus.flush_if_id}, 32'd0);
      rst = 1'b0;

      // pass-through
      set_id(1'b1, 15'h0800, 5'd1, 1'b1, 5'd2, 1'b0, 5'd5, 32'h100);
      tick();
      chk("pt_valid", {31'd0, bus.ex_valid}, 32'd1);
      chk("pt_ctrl", {17'd0, bus.ex_ctrl}, 32'h0800);
      chk("pt_rd", {27'd0, bus.ex_rd}, 32'd5);
      chk("pt_rs1", {27'd0, bus.ex_rs1}, 32'd1);
      chk("pt_pc", bus.ex_pc, 32'h100);

      // async reset mid-cycle with a live EX instruction
      rst = 1'b1;
      #1;
      chk("arst_valid", {31'd0, bus.ex_valid}, 32'd0);
      chk("arst_ctrl", {17'd0, bus.ex_ctrl}, 32'd0);
      chk("arst_pc", bus.ex_pc, 32'd0);
      chk("arst_stall", {31'd0, bus.stall_if_id}, 32'd0);
      rst = 1'b0;

      // load-use on rs2
      set_id(1'b1, 15'h4800, 5'd1, 1'b1, 5'd2, 1'b0, 5'd7, 32'h104);
      tick();
      set_id(1'b1, 15'h0800, 5'd1, 1'b1, 5'd7, 1'b1, 5'd8, 32'h108);
      chk("lu_stall", {31'd0, bus.stall_if_id}, 32'd1);
      chk("lu_flush", {31'd0, bus.flush_if_id}, 32'd0);
      tick();
      chk("lu_bub_valid", {31'd0, bus.ex_valid}, 32'd0);
      chk("lu_bub_pc", bus.ex_pc, 32'd0);
      chk("lu_stall_drop", {31'd0, bus.stall_if_id}, 32'd0);
      tick();
      chk("lu_cap_valid", {31'd0, bus.ex_valid}, 32'd1);
      chk("lu_cap_pc", bus.ex_pc, 32'h108);
      chk("lu_cap_rs2", {27'd0, bus.ex_rs2}, 32'd7);
`ifdef ID_EX_PERF_CNT_EN
      chk("lu_cnt", cnt_loaduse, 32'd1);
`endif

      // lbu to x0 never interlocks
      set_id(1'b1, 15'h0808, 5'd1, 1'b0, 5'd2, 1'b0, 5'd0, 32'h10c);
      tick();
      set_id(1'b1, 15'h0800, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 32'h110);
      chk("x0_stall", {31'd0, bus.stall_if_id}, 32'd0);
      tick();
      chk("x0_pc", bus.ex_pc, 32'h110);

      // lbu to x3, rs1 reads x3
      set_id(1'b1, 15'h0808, 5'd1, 1'b0, 5'd2, 1'b0, 5'd3, 32'h114);
      tick();
      set_id(1'b1, 15'h0800, 5'd3, 1'b0, 5'd0, 1'b0, 5'd4, 32'h118);
      chk("lbu_noread_stall", {31'd0, bus.stall_if_id}, 32'd0);
      set_id(1'b1, 15'h0800, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 32'h118);
      chk("lbu_stall", {31'd0, bus.stall_if_id}, 32'd1);
      tick();
      chk("lbu_bub", {31'd0, bus.ex_valid}, 32'd0);
      tick();
      chk("lbu_cap_pc", bus.ex_pc, 32'h118);
`ifdef ID_EX_PERF_CNT_EN
      chk("lbu_cnt", cnt_loaduse, 32'd2);
`endif

      // hazard and redirect together
      set_id(1'b1, 15'h4800, 5'd1, 1'b0, 5'd2, 1'b0, 5'd7, 32'h11c);
      tick();
      set_id(1'b1, 15'h0800, 5'd7, 1'b1, 5'd0, 1'b0, 5'd4, 32'h120);
      bus.ex_redirect = 1'b1;
      #1;
      chk("rd_flush", {31'd0, bus.flush_if_id}, 32'd1);
      chk("rd_stall", {31'd0, bus.stall_if_id}, 32'd0);
      tick();
      chk("rd_bub_valid", {31'd0, bus.ex_valid}, 32'd0);
      chk("rd_bub_ctrl", {17'd0, bus.ex_ctrl}, 32'd0);
`ifdef ID_EX_PERF_CNT_EN
      chk("rd_cnt_flush", cnt_flush, 32'd1);
      chk("rd_cnt_lu", cnt_loaduse, 32'd2);
`endif
      bus.ex_redirect = 1'b0;

      // halt beats redirect for 3 cycles
      set_id(1'b1, 15'h0800, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 32'h124);
      tick();
      chk("h_pre_pc", bus.ex_pc, 32'h124);
      bus.halt = 1'b1;
      bus.ex_redirect = 1'b1;
      set_id(1'b1, 15'h0400, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 32'h128);
      chk("h_stall", {31'd0, bus.stall_if_id}, 32'd1);
      chk("h_flush", {31'd0, bus.flush_if_id}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("h_pc", bus.ex_pc, 32'h124);
         chk("h_rd", {27'd0, bus.ex_rd}, 32'd10);
         chk("h_valid", {31'd0, bus.ex_valid}, 32'd1);
      end
`ifdef ID_EX_PERF_CNT_EN
      chk("h_cnt_flush", cnt_flush, 32'd1);
`endif
      bus.halt = 1'b0;
      bus.ex_redirect = 1'b0;
      tick();
      chk("h_rel_pc", bus.ex_pc, 32'h128);
      chk("h_rel_ctrl", {17'd0, bus.ex_ctrl}, 32'h0400);

      // back-to-back loads, each feeding the next
      set_id(1'b1, 15'h4800, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 32'h200);
      tick();
      set_id(1'b1, 15'h4800, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 32'h204);
      chk("bb1_stall", {31'd0, bus.stall_if_id}, 32'd1);
      tick();
      chk("bb1_bub", {31'd0, bus.ex_valid}, 32'd0);
      tick();
      chk("bb1_pc", bus.ex_pc, 32'h204);
      set_id(1'b1, 15'h0800, 5'd0, 1'b0, 5'd6, 1'b1, 5'd12, 32'h208);
      chk("bb2_stall", {31'd0, bus.stall_if_id}, 32'd1);
      tick();
      chk("bb2_bub", {31'd0, bus.ex_valid}, 32'd0);
      tick();
      chk("bb2_pc", bus.ex_pc, 32'h208);
`ifdef ID_EX_PERF_CNT_EN
      chk("bb_cnt", cnt_loaduse, 32'd4);
`endif

      // invalid ID instruction forces ctrl to zero
      set_id(1'b0, 15'h7fff, 5'd1, 1'b1, 5'd2, 1'b1, 5'd13, 32'h300);
      tick();
      chk("inv_valid", {31'd0, bus.ex_valid}, 32'd0);
      chk("inv_ctrl", {17'd0, bus.ex_ctrl}, 32'd0);
      chk("inv_pc", bus.ex_pc, 32'h300);

      // reset while stalled
      set_id(1'b1, 15'h4800, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 32'h304);
      tick();
      set_id(1'b1, 15'h0800, 5'd9, 1'b1, 5'd0, 1'b0, 5'd1, 32'h308);
      chk("rs_stall_pre", {31'd0, bus.stall_if_id}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rs_stall_post", {31'd0, bus.stall_if_id}, 32'd0);
      chk("rs_rd", {27'd0, bus.ex_rd}, 32'd0);
`ifdef ID_EX_PERF_CNT_EN
      chk("rs_cnt", cnt_loaduse, 32'd0);
`endif
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
